serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Parallel-to-serial frame transmitter. Accepts one DATA_W-bit word over a valid/ready
//   handshake and drives it onto a single-wire line as a framed bit stream:
//   start bit, data LSB-first, optional parity bit, stop bit.
//   Outgoing end of the team's serial byte link; pairs with a flop-based capture/receive
//   block downstream.
// PARAMETERS
//   DATA_W        8   data bits per frame (>=1)
//   CLKS_PER_BIT  4   clk cycles each bit is held on tx (>=1)
//   PARITY_EN     1   1: insert parity bit after data; 0: no parity bit
//   PARITY_ODD    0   0: even parity (bit = ^data); 1: odd parity (bit = ~^data)
// PORTS
//   clk       in   1       clock; all state updates on rising edge
//   reset     in   1       asynchronous, active-high reset
//   in_data   in   DATA_W  word to send; sampled only on handshake
//   in_valid  in   1       source has a word
//   in_ready  out  1       block can accept a word (high only in IDLE)
//   tx        out  1       serial line, idle high; registered output
//   busy      out  1       high from the cycle after accept until frame complete
//   done      out  1       one-cycle pulse when the stop bit has completed
// BEHAVIOUR
//   - Reset (async, immediate):
//       state=IDLE, tx=1, in_ready=1, busy=0, done=0,
//       bit and cycle counters=0, shift register=0.
//   - States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//   - Accept: in_valid && in_ready at a rising edge.
//       * latch in_data and compute the parity bit from the latched word;
//       * state=START; tx=0 starting the cycle after the edge.
//   - Bit timing: every bit (start/data/parity/stop) drives tx for exactly CLKS_PER_BIT
//     cycles. The cycle counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//   - DATA: sends bit 0 first. After DATA_W bits, goes to PARITY, or straight to STOP
//     when PARITY_EN=0.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. The next edge returns to IDLE, with
//     done=1, in_ready=1 and busy=0 in that first IDLE cycle.
//   - Frame length, accept edge to done cycle: (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
//   - Back-to-back: an accept on the edge that ends done's cycle starts the next
//     start bit with no idle gap.
//   - in_valid while busy is ignored. in_data changes while busy do not affect the
//     frame in flight.
//   - done is never high for more than one cycle. done and busy are never high together.
//   - tx is glitch-free: it only changes at bit boundaries or on reset.
//   - Reset mid-frame: tx returns to 1 immediately. The frame is aborted, done is not
//     pulsed, and the word is not retained.
//   - CLKS_PER_BIT=1 is legal: one bit per cycle, with no counter wrap corner cases.
// TESTING
//   1. Defaults, send 0xA5 -> tx, in 4-cycle bits: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
//      done pulses 44 cycles after the accept.
//   2. PARITY_ODD=1, send 0x34 -> data 0,0,1,0,1,1,0,0, parity 0, stop 1.
//      With PARITY_ODD=0 the parity bit is 1.
//   3. in_valid held high with 0x11 then 0x22 -> two frames with no idle gap;
//      in_ready=1 exactly in the done cycles; no word dropped or duplicated.
//   4. in_data toggled every cycle while busy (0xFF/0x00) after accepting 0x0F ->
//      the frame carries exactly 0x0F.
//   5. reset asserted in cycle 17 of the 0xA5 frame -> tx=1 before the next edge,
//      done never pulses; a new 0x3C accepted after release sends correctly.
//   6. CLKS_PER_BIT=1, PARITY_EN=0, send 0x80 -> tx 0,0,0,0,0,0,0,0,1,1;
//      done on cycle 10.

Source files
------------

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_tx
//  Description : Parallel-to-serial frame transmitter. Takes one word over a
//                valid/ready handshake and shifts it out on a single idle-high
//                line as start bit, data LSB-first, optional parity bit, and
//                stop bit. Every bit is held for CLKS_PER_BIT clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic [c_bit_w-1:0] bit_q,   bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q,   par_d;
    logic               tx_q,    tx_d;
    logic               done_q,  done_d;

    logic               w_bit_end;
    logic               w_accept;

    // Last clock of the current bit; with one clock per bit every cycle ends a bit.
    assign w_bit_end = (cnt_q == c_cnt_last);
    assign w_accept  = in_valid && (state_q == c_st_idle);

    assign in_ready  = (state_q == c_st_idle);
    assign busy      = (state_q != c_st_idle);
    assign tx        = tx_q;
    assign done      = done_q;

    // State and datapath registers; reset drops the frame and forces the line idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Frame sequencing: advance one field at each bit boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (in_valid) state_d = c_st_start;
            end
            c_st_start: begin
                if (w_bit_end) state_d = c_st_data;
            end
            c_st_data: begin
                if (w_bit_end && (bit_q == c_bit_last))
                    state_d = (PARITY_EN != 0) ? c_st_parity : c_st_stop;
            end
            c_st_parity: begin
                if (w_bit_end) state_d = c_st_stop;
            end
            c_st_stop: begin
                if (w_bit_end) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Counters, shifter and line value; tx is computed for the state being entered
    // so the registered line changes only when a new bit begins.
    always_comb begin
        cnt_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_d  = (state_q == c_st_stop) && w_bit_end;

        if ((state_q != c_st_idle) && !w_bit_end)
            cnt_d = cnt_q + c_cnt_w'(1);

        if (w_accept) begin
            shift_d = in_data;
            par_d   = (^in_data) ^ (PARITY_ODD != 0);
            bit_d   = '0;
        end

        if ((state_q == c_st_data) && w_bit_end) begin
            shift_d = shift_q >> 1;
            bit_d   = (bit_q == c_bit_last) ? '0 : bit_q + c_bit_w'(1);
        end

        case (state_d)
            c_st_start:  tx_d = 1'b0;
            c_st_data:   tx_d = shift_d[0];
            c_st_parity: tx_d = par_d;
            default:     tx_d = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_tx
//  Description : Bench for serial_frame_tx. Three configurations run side by
//                side on shared inputs and are checked every cycle against a
//                frame-position model, plus literal frame patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_ready_s;
    logic [2:0] tx_s;
    logic [2:0] busy_s;
    logic [2:0] done_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycles elapsed since accept (0 = idle) and the accepted word.
    int         n_m [3];
    logic [7:0] w_m [3];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s[2]), .tx(tx_s[2]), .busy(busy_s[2]), .done(done_s[2]));

    function automatic int cpb_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 1;
    endfunction

    function automatic int pen_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic logic podd_of(input int k);
        return (k == 1);
    endfunction

    // Cycles from accept edge to the edge that produces done.
    function automatic int len_of(input int k);
        return (10 + pen_of(k)) * cpb_of(k);
    endfunction

    // Model timeline: accept when idle (or in the done cycle) and valid, else count on.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                n_m[k] <= 0;
            end else if ((n_m[k] == 0) || (n_m[k] == len_of(k) + 1)) begin
                if (in_valid) begin
                    n_m[k] <= 1;
                    w_m[k] <= in_data;
                end else begin
                    n_m[k] <= 0;
                end
            end else begin
                n_m[k] <= n_m[k] + 1;
            end
        end
    end

    // Expected outputs from position within the frame.
    task automatic model_out(input int k, output logic etx, output logic ebusy,
                             output logic edone, output logic erdy);
        int b;
        int n;
        n = n_m[k];
        etx = 1'b1; ebusy = 1'b0; edone = 1'b0; erdy = 1'b1;
        if ((n >= 1) && (n <= len_of(k))) begin
            b = (n - 1) / cpb_of(k);
            ebusy = 1'b1;
            erdy  = 1'b0;
            if (b == 0)                          etx = 1'b0;
            else if (b <= 8)                     etx = w_m[k][b-1];
            else if ((pen_of(k) != 0) && b == 9) etx = (^w_m[k]) ^ podd_of(k);
            else                                 etx = 1'b1;
        end else if (n == len_of(k) + 1) begin
            edone = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic etx, ebusy, edone, erdy;
        for (int k = 0; k < 3; k++) begin
            model_out(k, etx, ebusy, edone, erdy);
            chk("tx",       k, 32'(tx_s[k]),       32'(etx));
            chk("busy",     k, 32'(busy_s[k]),     32'(ebusy));
            chk("done",     k, 32'(done_s[k]),     32'(edone));
            chk("in_ready", k, 32'(in_ready_s[k]), 32'(erdy));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle();
        int t;
        in_valid = 1'b0;
        t = 0;
        while ((in_ready_s != 3'b111) && (t < 200)) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout got %0b expected 111", in_ready_s);
        end
        tick();
    endtask

    // Send one word to all three instances and record the first clock of each bit.
    task automatic directed_send(input logic [7:0] word, input bit toggle,
                                 input logic [10:0] e0, input logic [10:0] e1,
                                 input logic [10:0] e2);
        logic [10:0] got [3];
        int          dly [3];
        for (int k = 0; k < 3; k++) begin
            got[k] = '0;
            dly[k] = -1;
        end
        in_data  = word;
        in_valid = 1'b1;
        for (int n = 1; n <= 46; n++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if ((n <= len_of(k)) && (((n - 1) % cpb_of(k)) == 0))
                    got[k][(n - 1) / cpb_of(k)] = tx_s[k];
                if (done_s[k] && (dly[k] < 0))
                    dly[k] = n - 1;
            end
            if (toggle) begin
                in_data  = (n % 2 == 1) ? 8'hFF : 8'h00;
                in_valid = (n < 40);
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("frame_bits", 0, 32'(got[0]), 32'(e0));
        chk("frame_bits", 1, 32'(got[1]), 32'(e1));
        chk("frame_bits", 2, 32'(got[2]), 32'(e2));
        chk("done_delay", 0, 32'(dly[0]), 32'd44);
        chk("done_delay", 1, 32'(dly[1]), 32'd33);
        chk("done_delay", 2, 32'(dly[2]), 32'd10);
        wait_idle();
    endtask

    initial begin
        int dcount;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        chk("rst_tx",    0, 32'(tx_s),       32'h7);
        chk("rst_ready", 0, 32'(in_ready_s), 32'h7);
        chk("rst_busy",  0, 32'(busy_s),     32'h0);
        chk("rst_done",  0, 32'(done_s),     32'h0);
        repeat (3) tick();
        #2 reset = 1'b0;
        tick();

        // Bit vectors: [0]=start, [8:1]=data LSB first, then parity (if any), stop.
        directed_send(8'hA5, 1'b0, 11'h54A, 11'h74A, 11'h34A);
        directed_send(8'h34, 1'b0, 11'h668, 11'h468, 11'h268);
        directed_send(8'h80, 1'b0, 11'h700, 11'h500, 11'h300);
        directed_send(8'h0F, 1'b1, 11'h41E, 11'h61E, 11'h21E);

        // Back-to-back frames with valid held high.
        in_data  = 8'h11;
        in_valid = 1'b1;
        dcount   = 0;
        for (int n = 1; n <= 90; n++) begin
            tick();
            if (n == 1) in_data = 8'h22;
            if (done_s[0]) dcount++;
            if (n == 46) chk("b2b_start", 0, 32'(tx_s[0]), 32'd0);
        end
        in_valid = 1'b0;
        chk("b2b_done_count", 0, 32'(dcount), 32'd2);
        wait_idle();

        // Reset in cycle 17 of a frame.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 2; n <= 17; n++) tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst_tx",   0, 32'(tx_s),   32'h7);
        chk("midrst_busy", 0, 32'(busy_s), 32'h0);
        chk("midrst_done", 0, 32'(done_s), 32'h0);
        repeat (2) tick();
        #2 reset = 1'b0;
        tick();
        directed_send(8'h3C, 1'b0, 11'h478, 11'h678, 11'h278);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            tick();
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                tick();
                #2 reset = 1'b0;
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
